seg_scan_display: RTL and testbench

SEG_SCAN_DISPLAY -- requirements
Module: seg_scan_display

---
 rtl/seg_scan_display.sv | 115 +++++++++++
 tb/tb_seg_scan_display.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_display.sv
// Four-digit multiplexed seven-segment driver with frame-synchronous display update
// and optional leading-zero blanking. All outputs are registered and active-low.
module seg_scan_display #(
    parameter int C_REFRESH_COUNT = 100000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] value,
    input  logic        value_valid,
    input  logic        blank_lz,
    output logic [6:0]  seg,
    output logic [3:0]  an,
    output logic        dp
);

    localparam int PW = (C_REFRESH_COUNT > 1) ? $clog2(C_REFRESH_COUNT) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(C_REFRESH_COUNT - 1);

    logic [PW-1:0] prescaler_r;
    logic [1:0]    index_r;
    logic [15:0]   capture_r;
    logic [15:0]   display_r;
    logic [6:0]    seg_r;
    logic [3:0]    an_r;
    logic          dp_r;

    logic          tick_s;
    logic          frame_end_s;
    logic [3:0]    nibble_s;
    logic          blank_s;
    logic [3:0]    an_s;

    // Hex nibble to active-low segment pattern, bit order g..a
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'h0:    pat = 7'b1000000;
            4'h1:    pat = 7'b1111001;
            4'h2:    pat = 7'b0100100;
            4'h3:    pat = 7'b0110000;
            4'h4:    pat = 7'b0011001;
            4'h5:    pat = 7'b0010010;
            4'h6:    pat = 7'b0000010;
            4'h7:    pat = 7'b1111000;
            4'h8:    pat = 7'b0000000;
            4'h9:    pat = 7'b0010000;
            4'hA:    pat = 7'b0001000;
            4'hB:    pat = 7'b0000011;
            4'hC:    pat = 7'b1000110;
            4'hD:    pat = 7'b0100001;
            4'hE:    pat = 7'b0000110;
            4'hF:    pat = 7'b0001110;
            default: pat = 7'b1111111;
        endcase
        return pat;
    endfunction

    // Slot timing, digit selection and leading-zero blanking decision
    always_comb begin
        tick_s      = (prescaler_r == PRESC_MAX);
        frame_end_s = tick_s && (index_r == 2'd3);
        nibble_s    = display_r[{index_r, 2'b00} +: 4];
        if (blank_lz) begin
            case (index_r)
                2'd0:    blank_s = 1'b0;
                2'd1:    blank_s = (display_r[15:4] == 12'h000);
                2'd2:    blank_s = (display_r[15:8] == 8'h00);
                2'd3:    blank_s = (display_r[15:12] == 4'h0);
                default: blank_s = 1'b0;
            endcase
        end else begin
            blank_s = 1'b0;
        end
        if (blank_s) begin
            an_s = 4'b1111;
        end else begin
            an_s = ~(4'b0001 << index_r);
        end
    end

    // Scan state, capture/display registers and registered pin drivers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prescaler_r <= '0;
            index_r     <= 2'd0;
            capture_r   <= 16'h0000;
            display_r   <= 16'h0000;
            seg_r       <= 7'b1111111;
            an_r        <= 4'b1111;
            dp_r        <= 1'b1;
        end else begin
            if (tick_s) begin
                prescaler_r <= '0;
                index_r     <= index_r + 2'd1;
            end else begin
                prescaler_r <= prescaler_r + PW'(1);
            end
            if (value_valid) begin
                capture_r <= value;
            end
            // Display only changes between frames; a same-edge capture shows next frame
            if (frame_end_s) begin
                display_r <= capture_r;
            end
            seg_r <= hex_to_seg(nibble_s);
            an_r  <= an_s;
            dp_r  <= 1'b1;
        end
    end

    assign seg = seg_r;
    assign an  = an_r;
    assign dp  = dp_r;

endmodule

// File: tb/tb_seg_scan_display.sv
// Bench for seg_scan_display: table vectors, hand-written corner sequences and a
// randomized run checked every cycle against a frame-arithmetic reference model.
module tb_seg_scan_display;

    logic        clk;
    logic        rst_n;
    logic [15:0] value;
    logic        value_valid;
    logic        blank_lz;
    logic [6:0]  seg4, seg1;
    logic [3:0]  an4, an1;
    logic        dp4, dp1;

    int n_checks = 0;
    int n_fail   = 0;
    logic chk_en = 1'b0;

    seg_scan_display #(.C_REFRESH_COUNT(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .value(value), .value_valid(value_valid),
        .blank_lz(blank_lz), .seg(seg4), .an(an4), .dp(dp4)
    );

    seg_scan_display #(.C_REFRESH_COUNT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .value(value), .value_valid(value_valid),
        .blank_lz(blank_lz), .seg(seg1), .an(an1), .dp(dp1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [6:0] hex_tab [0:15] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
        end
    endtask

    // Reference model: the slot is pure arithmetic on clocks since reset
    int          cnt_m  [2];
    int          cap_m  [2];
    int          disp_m [2];
    logic [6:0]  eseg   [2];
    logic [3:0]  ean    [2];

    function automatic int cfg(input int k);
        return (k == 0) ? 4 : 1;
    endfunction

    function automatic int slot_of(input int cnt, input int k);
        return (cnt / cfg(k)) % 4;
    endfunction

    function automatic logic [3:0] an_for(input int d, input int i, input logic b);
        logic [3:0] r;
        r = 4'b1111;
        if (!(b && i > 0 && (d >> (4 * i)) == 0)) r[i] = 1'b0;
        return r;
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                cnt_m[k]  <= 0;
                cap_m[k]  <= 0;
                disp_m[k] <= 0;
                eseg[k]   <= 7'b1111111;
                ean[k]    <= 4'b1111;
            end else begin
                eseg[k] <= hex_tab[(disp_m[k] >> (4 * slot_of(cnt_m[k], k))) & 15];
                ean[k]  <= an_for(disp_m[k], slot_of(cnt_m[k], k), blank_lz);
                if (value_valid) cap_m[k] <= int'(value);
                if (cnt_m[k] == 4 * cfg(k) - 1) disp_m[k] <= cap_m[k];
                cnt_m[k] <= (cnt_m[k] + 1) % (4 * cfg(k));
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_seg_c4", {9'd0, seg4}, {9'd0, eseg[0]});
            check("model_an_c4",  {12'd0, an4}, {12'd0, ean[0]});
            check("model_dp_c4",  {15'd0, dp4}, 16'd1);
            check("model_seg_c1", {9'd0, seg1}, {9'd0, eseg[1]});
            check("model_an_c1",  {12'd0, an1}, {12'd0, ean[1]});
            check("model_dp_c1",  {15'd0, dp1}, 16'd1);
        end
    end

    typedef struct packed {
        logic [15:0]     value;
        logic            blank;
        logic [3:0][6:0] seg;
        logic [3:0][3:0] an;
    } vec_t;

    vec_t vecs [7];

    // One reset cycle, then release with an optional capture strobe on the first edge
    task automatic release_with(input logic [15:0] v, input logic p);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n       = 1'b1;
        value       = v;
        value_valid = p;
        @(negedge clk);
        value_valid = 1'b0;
    endtask

    initial begin
        vecs[0] = '{16'h12AF, 1'b0, {7'b1111001, 7'b0100100, 7'b0001000, 7'b0001110},
                    {4'b0111, 4'b1011, 4'b1101, 4'b1110}};
        vecs[1] = '{16'h0005, 1'b1, {7'b1000000, 7'b1000000, 7'b1000000, 7'b0010010},
                    {4'b1111, 4'b1111, 4'b1111, 4'b1110}};
        vecs[2] = '{16'h0000, 1'b1, {7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000},
                    {4'b1111, 4'b1111, 4'b1111, 4'b1110}};
        vecs[3] = '{16'h0F00, 1'b1, {7'b1000000, 7'b0001110, 7'b1000000, 7'b1000000},
                    {4'b1111, 4'b1011, 4'b1101, 4'b1110}};
        vecs[4] = '{16'hBCDE, 1'b0, {7'b0000011, 7'b1000110, 7'b0100001, 7'b0000110},
                    {4'b0111, 4'b1011, 4'b1101, 4'b1110}};
        vecs[5] = '{16'h6789, 1'b1, {7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000},
                    {4'b0111, 4'b1011, 4'b1101, 4'b1110}};
        vecs[6] = '{16'h0000, 1'b0, {7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000},
                    {4'b0111, 4'b1011, 4'b1101, 4'b1110}};

        rst_n = 1'b0; value = 16'h0000; value_valid = 1'b0; blank_lz = 1'b0;
        @(negedge clk);
        chk_en = 1'b1;
        check("reset_seg", {9'd0, seg4}, 16'h007F);
        check("reset_an",  {12'd0, an4}, 16'h000F);
        check("reset_dp",  {15'd0, dp4}, 16'd1);

        // Table: capture on release, inspect every slot of the following frame
        for (int v = 0; v < 7; v++) begin
            blank_lz = vecs[v].blank;
            release_with(vecs[v].value, 1'b1);
            repeat (16) @(negedge clk);
            for (int d = 0; d < 4; d++) begin
                check($sformatf("vec%0d_seg_d%0d", v, d), {9'd0, seg4}, {9'd0, vecs[v].seg[d]});
                check($sformatf("vec%0d_an_d%0d", v, d), {12'd0, an4}, {12'd0, vecs[v].an[d]});
                repeat (4) @(negedge clk);
            end
        end

        // Strobe on the frame-boundary edge: old capture shows first
        blank_lz = 1'b0;
        release_with(16'h1111, 1'b1);
        repeat (14) @(negedge clk);
        value = 16'h3333; value_valid = 1'b1;
        @(negedge clk);
        value_valid = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 4; d++) begin
            check("boundary_old_seg", {9'd0, seg4}, 16'h0079);
            repeat (4) @(negedge clk);
        end
        check("boundary_new_seg", {9'd0, seg4}, 16'h0030);
        check("boundary_new_an",  {12'd0, an4}, 16'h000E);

        // Reset pulse in the middle of the digit-2 slot discards the pending capture
        release_with(16'h9999, 1'b1);
        repeat (9) @(negedge clk);
        check("mid_d2_an", {12'd0, an4}, 16'h000B);
        rst_n = 1'b0; value = 16'h7777; value_valid = 1'b1;
        @(negedge clk);
        check("midrst_an",  {12'd0, an4}, 16'h000F);
        check("midrst_seg", {9'd0, seg4}, 16'h007F);
        rst_n = 1'b1; value_valid = 1'b0;
        @(negedge clk);
        check("restart_an",  {12'd0, an4}, 16'h000E);
        check("restart_seg", {9'd0, seg4}, 16'h0040);
        repeat (16) @(negedge clk);
        check("discard_seg", {9'd0, seg4}, 16'h0040);
        check("discard_an",  {12'd0, an4}, 16'h000E);

        // Refresh count of one: digit advances every clock
        release_with(16'h4321, 1'b1);
        repeat (4) @(negedge clk);
        for (int d = 0; d < 4; d++) begin
            logic [3:0] ea;
            ea = 4'b1111;
            ea[d] = 1'b0;
            check($sformatf("c1_seg_d%0d", d), {9'd0, seg1}, {9'd0, hex_tab[d + 1]});
            check($sformatf("c1_an_d%0d", d), {12'd0, an1}, {12'd0, ea});
            @(negedge clk);
        end

        // Randomized run, checked cycle by cycle by the model
        for (int i = 0; i < 4000; i++) begin
            rst_n       = ($urandom_range(0, 299) != 0);
            value_valid = ($urandom_range(0, 9) == 0);
            value       = 16'($urandom);
            if ($urandom_range(0, 3) == 0) value[15:8] = 8'h00;
            if ($urandom_range(0, 63) == 0) blank_lz = ~blank_lz;
            @(negedge clk);
        end

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
